can_tx_arbiter: RTL

CAN_TX_ARBITER -- requirements
Module: can_tx_arbiter

---
 rtl/can_tx_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/can_tx_arbiter.sv
// CAN transmit-side arbiter: picks the lowest-ID pending mailbox once the bus is idle,
// drives SOF and the 11-bit identifier bit-by-bit, and hands the bus to a frame transmitter.
module can_tx_arbiter #(
  parameter int NUM_MB    = 4,
  parameter int IDLE_BITS = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_tick,
  input  logic                      rxd,
  output logic                      txd,
  input  logic [NUM_MB-1:0]         mb_load,
  input  logic [10:0]               mb_id,
  input  logic [NUM_MB-1:0]         mb_abort,
  output logic [NUM_MB-1:0]         mb_pending,
  output logic [$clog2(NUM_MB)-1:0] sel_mb,
  output logic                      arb_active,
  output logic                      arb_won,
  output logic                      arb_lost,
  output logic                      tx_grant,
  input  logic                      tx_done,
  input  logic                      tx_error,
  output logic                      tx_ok,
  output logic [3:0]                retry_cnt
);

  localparam int SEL_W = $clog2(NUM_MB);
  localparam int CNT_W = $clog2(IDLE_BITS + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SOF,
    S_ARB,
    S_GRANT
  } state_t;

  state_t             state_q, state_d;
  logic               txd_q, txd_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [10:0]        cur_id_q, cur_id_d;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         bit_idx_m1;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic               arb_active_q, arb_active_d;
  logic               arb_won_q, arb_won_d;
  logic               arb_lost_q, arb_lost_d;
  logic               tx_grant_q, tx_grant_d;
  logic               tx_ok_q, tx_ok_d;
  logic               clr_sel;
  logic               retry_inc;

  logic [NUM_MB-1:0]  pend_vec;
  logic [10:0]        slot_id [NUM_MB];

  logic [SEL_W-1:0]   best_idx;
  logic [10:0]        best_id;
  logic               any_pending;

  // Mailbox slots; the slot owned by an in-flight attempt is frozen against load/abort.
  for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_slot
    logic        pend_q, pend_d;
    logic [10:0] id_q, id_d;
    logic        locked;

    assign locked       = (state_q != S_IDLE) && (sel_q == SEL_W'(gi));
    assign pend_vec[gi] = pend_q;
    assign slot_id[gi]  = id_q;

    always_comb begin
      pend_d = pend_q;
      id_d   = id_q;
      if (locked) begin
        if (clr_sel) pend_d = 1'b0;
      end else if (mb_abort[gi]) begin
        pend_d = 1'b0;
      end else if (mb_load[gi]) begin
        pend_d = 1'b1;
        id_d   = mb_id;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q <= 1'b0;
        id_q   <= '0;
      end else begin
        pend_q <= pend_d;
        id_q   <= id_d;
      end
    end
  end

  // Lowest identifier wins; strict compare keeps the lower index on a tie.
  always_comb begin
    best_idx    = '0;
    best_id     = '1;
    any_pending = 1'b0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pend_vec[i] && (!any_pending || slot_id[i] < best_id)) begin
        best_idx    = SEL_W'(i);
        best_id     = slot_id[i];
        any_pending = 1'b1;
      end
    end
  end

  assign bit_idx_m1 = bit_idx_q - 4'd1;

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    sel_d      = sel_q;
    cur_id_d   = cur_id_q;
    bit_idx_d  = bit_idx_q;
    idle_cnt_d = idle_cnt_q;
    retry_d    = retry_q;
    tx_grant_d = tx_grant_q;
    arb_won_d  = 1'b0;
    arb_lost_d = 1'b0;
    tx_ok_d    = 1'b0;
    clr_sel    = 1'b0;
    retry_inc  = 1'b0;

    if (bit_tick && state_q != S_GRANT) begin
      if (!rxd) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != IDLE_MAX) begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (idle_cnt_q == IDLE_MAX && any_pending) begin
          sel_d    = best_idx;
          cur_id_d = best_id;
          txd_d    = 1'b0;
          state_d  = S_SOF;
        end
      end
      S_SOF: begin
        if (bit_tick) begin
          if (!rxd) begin
            txd_d     = cur_id_q[10];
            bit_idx_d = 4'd10;
            state_d   = S_ARB;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_ARB: begin
        if (bit_tick) begin
          if (txd_q && !rxd) begin
            txd_d      = 1'b1;
            arb_lost_d = 1'b1;
            retry_inc  = 1'b1;
            state_d    = S_IDLE;
          end else if (bit_idx_q == 4'd0) begin
            txd_d      = 1'b1;
            arb_won_d  = 1'b1;
            tx_grant_d = 1'b1;
            state_d    = S_GRANT;
          end else begin
            bit_idx_d = bit_idx_m1;
            txd_d     = cur_id_q[bit_idx_m1];
          end
        end
      end
      S_GRANT: begin
        txd_d = 1'b1;
        if (tx_done) begin
          clr_sel    = 1'b1;
          tx_ok_d    = 1'b1;
          retry_d    = 4'd0;
          tx_grant_d = 1'b0;
          state_d    = S_IDLE;
        end else if (tx_error) begin
          retry_inc  = 1'b1;
          tx_grant_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (retry_inc && retry_q != 4'hF) retry_d = retry_q + 4'd1;
    // Every return to IDLE demands a fresh run of recessive bits.
    if (state_q != S_IDLE && state_d == S_IDLE) idle_cnt_d = '0;
    arb_active_d = (state_d == S_SOF) || (state_d == S_ARB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      txd_q        <= 1'b1;
      sel_q        <= '0;
      cur_id_q     <= '0;
      bit_idx_q    <= '0;
      idle_cnt_q   <= '0;
      retry_q      <= '0;
      arb_active_q <= 1'b0;
      arb_won_q    <= 1'b0;
      arb_lost_q   <= 1'b0;
      tx_grant_q   <= 1'b0;
      tx_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      txd_q        <= txd_d;
      sel_q        <= sel_d;
      cur_id_q     <= cur_id_d;
      bit_idx_q    <= bit_idx_d;
      idle_cnt_q   <= idle_cnt_d;
      retry_q      <= retry_d;
      arb_active_q <= arb_active_d;
      arb_won_q    <= arb_won_d;
      arb_lost_q   <= arb_lost_d;
      tx_grant_q   <= tx_grant_d;
      tx_ok_q      <= tx_ok_d;
    end
  end

  assign txd        = txd_q;
  assign mb_pending = pend_vec;
  assign sel_mb     = sel_q;
  assign arb_active = arb_active_q;
  assign arb_won    = arb_won_q;
  assign arb_lost   = arb_lost_q;
  assign tx_grant   = tx_grant_q;
  assign tx_ok      = tx_ok_q;
  assign retry_cnt  = retry_q;

endmodule
